// File: rtl/sram_port_arbiter_if.sv
// sram_port_arbiter_if
//   Bundles the shared-SRAM access signals: requester-side req/grant
//   handshake, packed per-requester address/data slices, read-data return,
//   and the single physical SRAM port.
//
//   Requester side : req, grant, req_raddr, req_waddr, req_wdata,
//                    req_wr_enable, rdata, req_rvalid, busy
//   SRAM side      : sram_raddr, sram_rdata, sram_waddr, sram_wdata,
//                    sram_wr_enable
//
//   slave  : the arbiter's view (drives grant, read return and the SRAM port)
//   master : the environment's view (requesters plus the SRAM device)
interface sram_port_arbiter_if #(
  parameter int AW   = 18,
  parameter int DW   = 16,
  parameter int NREQ = 4
);
  logic [NREQ-1:0]    req;
  logic [NREQ-1:0]    grant;
  logic [NREQ*AW-1:0] req_raddr;
  logic [NREQ*AW-1:0] req_waddr;
  logic [NREQ*DW-1:0] req_wdata;
  logic [NREQ-1:0]    req_wr_enable;
  logic [DW-1:0]      rdata;
  logic [NREQ-1:0]    req_rvalid;
  logic [AW-1:0]      sram_raddr;
  logic [DW-1:0]      sram_rdata;
  logic [AW-1:0]      sram_waddr;
  logic [DW-1:0]      sram_wdata;
  logic               sram_wr_enable;
  logic               busy;

  modport slave (
    input  req, req_raddr, req_waddr, req_wdata, req_wr_enable, sram_rdata,
    output grant, rdata, req_rvalid, sram_raddr, sram_waddr, sram_wdata,
           sram_wr_enable, busy
  );

  modport master (
    output req, req_raddr, req_waddr, req_wdata, req_wr_enable, sram_rdata,
    input  grant, rdata, req_rvalid, sram_raddr, sram_waddr, sram_wdata,
           sram_wr_enable, busy
  );
endinterface

// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter
//   Round-robin arbiter that shares one SRAM read/write port among NREQ
//   requesters. A requester holds req high for as long as it wants the bus;
//   the owner may keep it indefinitely unless someone else is waiting, in
//   which case it is pre-empted after MAX_BURST granted cycles. Every change
//   of owner passes through one IDLE cycle with no grant, so no write can be
//   driven while the bus turns around. Each read is tagged with its issuer
//   and its valid is steered back to that requester RD_LAT cycles later,
//   even if the bus has changed hands in between.
//
//   Ports
//     clk    : clock
//     reset  : asynchronous, active-low reset
//     bus    : sram_port_arbiter_if.slave
//              req/grant handshake, packed requester slices
//              (requester i at [i*AW +: AW] / [i*DW +: DW]), read return
//              (rdata broadcast, req_rvalid one-hot), SRAM port, busy
module sram_port_arbiter #(
  parameter int AW        = 18,
  parameter int DW        = 16,
  parameter int NREQ      = 4,
  parameter int MAX_BURST = 64,
  parameter int RD_LAT    = 1
) (
  input  logic               clk,
  input  logic               reset,
  sram_port_arbiter_if.slave bus
);

  localparam int OW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int BW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [BW-1:0] BURST_LAST = BW'(MAX_BURST - 1);
  localparam logic [OW-1:0] LAST_REQ   = OW'(NREQ - 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t        state, next_state;
  logic [OW-1:0] owner, next_owner;
  logic [OW-1:0] rr_ptr, next_rr_ptr;
  logic [BW-1:0] burst_cnt, next_burst_cnt;

  logic [OW-1:0] winner;
  logic [OW-1:0] scan_idx;
  logic          winner_found;

  logic [NREQ-1:0] owner_mask;
  logic            owner_req;
  logic            owner_wr;
  logic            others_req;
  logic            release_bus;
  logic            rd_issue;

  logic [AW-1:0] raddr_arr [NREQ];
  logic [AW-1:0] waddr_arr [NREQ];
  logic [DW-1:0] wdata_arr [NREQ];

  logic          rd_valid_pipe [RD_LAT];
  logic [OW-1:0] rd_tag_pipe   [RD_LAT];

  function automatic logic [NREQ-1:0] to_onehot(input logic [OW-1:0] idx);
    logic [NREQ-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  // Split the packed requester buses into per-requester words so the owner
  // mux below is a plain array index.
  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign raddr_arr[g] = bus.req_raddr[g*AW +: AW];
    assign waddr_arr[g] = bus.req_waddr[g*AW +: AW];
    assign wdata_arr[g] = bus.req_wdata[g*DW +: DW];
  end

  // Round-robin pick: first asserted req at or above rr_ptr, wrapping.
  always_comb begin
    winner       = '0;
    winner_found = 1'b0;
    scan_idx     = '0;
    for (int i = 0; i < NREQ; i++) begin
      scan_idx = OW'((int'(rr_ptr) + i) % NREQ);
      if (!winner_found && bus.req[scan_idx]) begin
        winner       = scan_idx;
        winner_found = 1'b1;
      end
    end
  end

  // Owner-side view of the request lines; everything from non-owners is
  // masked off here and never reaches the SRAM port.
  always_comb begin
    owner_mask = to_onehot(owner);
    owner_req  = (state == GRANT) && bus.req[owner];
    owner_wr   = owner_req && bus.req_wr_enable[owner];
    rd_issue   = owner_req && !bus.req_wr_enable[owner];
    others_req = |(bus.req & ~owner_mask);
  end

  // State, owner, round-robin pointer and burst counter registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      owner     <= '0;
      rr_ptr    <= '0;
      burst_cnt <= '0;
    end else begin
      state     <= next_state;
      owner     <= next_owner;
      rr_ptr    <= next_rr_ptr;
      burst_cnt <= next_burst_cnt;
    end
  end

  // Next-state logic. A release always returns to IDLE, which is what
  // provides the turnaround cycle between owners. With no competitor the
  // burst counter simply wraps and the owner keeps the bus.
  always_comb begin
    next_state     = state;
    next_owner     = owner;
    next_rr_ptr    = rr_ptr;
    next_burst_cnt = burst_cnt;
    release_bus    = 1'b0;
    unique case (state)
      IDLE: begin
        if (winner_found) begin
          next_state     = GRANT;
          next_owner     = winner;
          next_burst_cnt = '0;
        end
      end
      GRANT: begin
        release_bus = !bus.req[owner] || ((burst_cnt == BURST_LAST) && others_req);
        if (release_bus) begin
          next_state     = IDLE;
          next_burst_cnt = '0;
          next_rr_ptr    = (owner == LAST_REQ) ? '0 : owner + 1'b1;
        end else if (burst_cnt == BURST_LAST) begin
          next_burst_cnt = '0;
        end else begin
          next_burst_cnt = burst_cnt + 1'b1;
        end
      end
    endcase
  end

  // SRAM port is driven only while someone owns the bus; otherwise all zero.
  always_comb begin
    bus.sram_raddr     = '0;
    bus.sram_waddr     = '0;
    bus.sram_wdata     = '0;
    bus.sram_wr_enable = 1'b0;
    if (state == GRANT) begin
      bus.sram_raddr     = raddr_arr[owner];
      bus.sram_waddr     = waddr_arr[owner];
      bus.sram_wdata     = wdata_arr[owner];
      bus.sram_wr_enable = owner_wr;
    end
  end

  // Read tag pipeline: one entry per cycle, so the valid emerging at the end
  // lines up with SRAM data for the read issued RD_LAT cycles earlier. It
  // runs independently of the grant so tags survive a handover.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < RD_LAT; i++) begin
        rd_valid_pipe[i] <= 1'b0;
        rd_tag_pipe[i]   <= '0;
      end
    end else begin
      rd_valid_pipe[0] <= rd_issue;
      rd_tag_pipe[0]   <= owner;
      for (int i = 1; i < RD_LAT; i++) begin
        rd_valid_pipe[i] <= rd_valid_pipe[i-1];
        rd_tag_pipe[i]   <= rd_tag_pipe[i-1];
      end
    end
  end

  assign bus.grant      = (state == GRANT) ? owner_mask : '0;
  assign bus.busy       = (state == GRANT);
  assign bus.rdata      = bus.sram_rdata;
  assign bus.req_rvalid = rd_valid_pipe[RD_LAT-1] ? to_onehot(rd_tag_pipe[RD_LAT-1]) : '0;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// tb_sram_port_arbiter
//   Directed bench for sram_port_arbiter (NREQ=4, MAX_BURST=4, RD_LAT=1).
//   Stimulus pushes the expected grant runs (owner, length) and expected
//   read returns (tag, data) into queues; a monitor on the falling edge pops
//   and compares them whenever the DUT shows a grant run ending or an rvalid.
//   The SRAM is modelled as a one-cycle registered read of an address hash.
module tb_sram_port_arbiter;

  localparam int AW        = 18;
  localparam int DW        = 16;
  localparam int NREQ      = 4;
  localparam int MAX_BURST = 4;
  localparam int RD_LAT    = 1;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  sram_port_arbiter_if #(.AW(AW), .DW(DW), .NREQ(NREQ)) bus ();

  sram_port_arbiter #(
    .AW(AW), .DW(DW), .NREQ(NREQ), .MAX_BURST(MAX_BURST), .RD_LAT(RD_LAT)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NREQ-1:0] value;
    int              len;
  } run_t;

  typedef struct {
    logic [NREQ-1:0] tag_mask;
    logic [DW-1:0]   data;
  } rd_t;

  run_t exp_runs [$];
  rd_t  exp_reads[$];

  int checks   = 0;
  int failures = 0;

  logic [AW-1:0] raddr [NREQ];
  logic [AW-1:0] waddr [NREQ];
  logic [DW-1:0] wdata [NREQ];

  // SRAM contents are a fixed hash of the address.
  function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
    return a[15:0] ^ 16'h5A3C;
  endfunction

  always @(posedge clk) bus.sram_rdata <= mem_word(bus.sram_raddr);

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, expected);
    end
  endtask

  // Drive one cycle of requester inputs just after the falling edge, then
  // step 1 time unit so combinational outputs can be checked.
  task automatic apply_stimulus(input logic [NREQ-1:0] r, input logic [NREQ-1:0] we);
    @(negedge clk);
    for (int i = 0; i < NREQ; i++) begin
      bus.req_raddr[i*AW +: AW] = raddr[i];
      bus.req_waddr[i*AW +: AW] = waddr[i];
      bus.req_wdata[i*DW +: DW] = wdata[i];
    end
    bus.req           = r;
    bus.req_wr_enable = we;
    #1;
  endtask

  task automatic do_reset();
    apply_stimulus('0, '0);
    reset = 1'b0;
    apply_stimulus('0, '0);
    reset = 1'b1;
  endtask

  task automatic push_run(input logic [NREQ-1:0] v, input int len);
    exp_runs.push_back('{value: v, len: len});
  endtask

  task automatic push_read(input int tag, input logic [AW-1:0] a);
    rd_t e;
    e.tag_mask = '0;
    e.tag_mask[tag] = 1'b1;
    e.data = mem_word(a);
    exp_reads.push_back(e);
  endtask

  // Monitor: grant runs and read returns, sampled on the falling edge.
  logic [NREQ-1:0] prev_grant = '0;
  int              run_len    = 0;

  always @(negedge clk) begin
    if (bus.grant !== prev_grant) begin
      if (prev_grant != '0) begin
        if (exp_runs.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL grant_run actual=%0h required=none", prev_grant);
        end else begin
          run_t e;
          e = exp_runs.pop_front();
          check_output("grant_run_owner", 32'(prev_grant), 32'(e.value));
          check_output("grant_run_len", run_len, e.len);
        end
        check_output("turnaround_gap", 32'(bus.grant), 32'd0);
      end
      prev_grant = bus.grant;
      run_len    = 1;
    end else begin
      run_len++;
    end
    if (bus.req_rvalid !== '0) begin
      if (exp_reads.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL rvalid actual=%0h required=none", bus.req_rvalid);
      end else begin
        rd_t r;
        r = exp_reads.pop_front();
        check_output("rvalid_tag", 32'(bus.req_rvalid), 32'(r.tag_mask));
        check_output("rvalid_data", 32'(bus.rdata), 32'(r.data));
      end
    end
  end

  initial begin
    bus.req           = '0;
    bus.req_wr_enable = '0;
    bus.req_raddr     = '0;
    bus.req_waddr     = '0;
    bus.req_wdata     = '0;
    for (int i = 0; i < NREQ; i++) begin
      raddr[i] = 18'h3FF00 + 18'(i);
      waddr[i] = 18'h2AA00 + 18'(i);
      wdata[i] = 16'hC000 + 16'(i);
    end
    #1 reset = 1'b0;

    // Reset state with every requester shouting: nothing may leak through.
    apply_stimulus(4'b1111, 4'b1111);
    check_output("reset_grant", 32'(bus.grant), 32'd0);
    check_output("reset_busy", 32'(bus.busy), 32'd0);
    check_output("reset_rvalid", 32'(bus.req_rvalid), 32'd0);
    check_output("reset_wr_enable", 32'(bus.sram_wr_enable), 32'd0);
    check_output("reset_raddr", 32'(bus.sram_raddr), 32'd0);
    check_output("reset_waddr", 32'(bus.sram_waddr), 32'd0);
    check_output("reset_wdata", 32'(bus.sram_wdata), 32'd0);
    apply_stimulus('0, '0);
    reset = 1'b1;

    // Single requester reading a new address every cycle for 10 cycles.
    push_run(4'b0001, 10);
    for (int j = 0; j < 10; j++) begin
      raddr[0] = 18'h00100 + 18'(j);
      apply_stimulus(4'b0001, 4'b0000);
      if (j >= 1) push_read(0, raddr[0]);
      if (j == 1) begin
        check_output("single_grant", 32'(bus.grant), 32'h1);
        check_output("single_busy", 32'(bus.busy), 32'd1);
      end
      if (j == 3) check_output("single_raddr", 32'(bus.sram_raddr), 32'h00103);
    end
    apply_stimulus('0, '0);
    check_output("single_grant_before_release", 32'(bus.grant), 32'h1);
    apply_stimulus('0, '0);
    check_output("single_released", 32'(bus.grant), 32'd0);

    // Contention: 0,1,3 all writing; rotation 0 -> 1 -> 3 -> 0, 4 cycles each.
    do_reset();
    push_run(4'b0001, 4);
    push_run(4'b0010, 4);
    push_run(4'b1000, 4);
    push_run(4'b0001, 4);
    for (int j = 0; j < 19; j++) begin
      apply_stimulus(4'b1011, 4'b1111);
      if (j == 5) begin
        check_output("contention_idle_grant", 32'(bus.grant), 32'd0);
        check_output("contention_idle_no_write", 32'(bus.sram_wr_enable), 32'd0);
      end
      if (j == 7) begin
        check_output("contention_wr_enable", 32'(bus.sram_wr_enable), 32'd1);
        check_output("contention_waddr", 32'(bus.sram_waddr), 32'(waddr[1]));
      end
    end
    apply_stimulus('0, 4'b1111);
    apply_stimulus('0, '0);
    apply_stimulus('0, '0);

    // Burst limit with no competitor: grant must stay continuous.
    do_reset();
    push_run(4'b0100, 12);
    for (int j = 0; j < 12; j++) begin
      apply_stimulus(4'b0100, 4'b0100);
      if (j == 5) check_output("solo_grant_after_wrap", 32'(bus.grant), 32'h4);
      if (j == 6) begin
        check_output("solo_wr_enable", 32'(bus.sram_wr_enable), 32'd1);
        check_output("solo_waddr", 32'(bus.sram_waddr), 32'(waddr[2]));
        check_output("solo_wdata", 32'(bus.sram_wdata), 32'(wdata[2]));
      end
    end
    apply_stimulus('0, '0);
    apply_stimulus('0, '0);

    // Write masking: non-owner wr_enable and owner dropping req.
    do_reset();
    raddr[1] = 18'h00222;
    push_run(4'b0010, 3);
    apply_stimulus(4'b0010, 4'b0001);
    check_output("idle_raddr_zero", 32'(bus.sram_raddr), 32'd0);
    check_output("idle_wr_enable", 32'(bus.sram_wr_enable), 32'd0);
    apply_stimulus(4'b0010, 4'b0001);
    check_output("mask_grant", 32'(bus.grant), 32'h2);
    check_output("nonowner_wr_enable", 32'(bus.sram_wr_enable), 32'd0);
    push_read(1, raddr[1]);
    apply_stimulus(4'b0010, 4'b0011);
    check_output("owner_wr_enable", 32'(bus.sram_wr_enable), 32'd1);
    check_output("owner_waddr", 32'(bus.sram_waddr), 32'(waddr[1]));
    check_output("owner_wdata", 32'(bus.sram_wdata), 32'(wdata[1]));
    apply_stimulus(4'b0000, 4'b0010);
    check_output("drop_grant_still", 32'(bus.grant), 32'h2);
    check_output("owner_drop_wr_enable", 32'(bus.sram_wr_enable), 32'd0);
    apply_stimulus('0, '0);
    check_output("mask_released", 32'(bus.grant), 32'd0);

    // Read tag across handover: owner 0 reads 0x00010 in its last cycle.
    do_reset();
    push_run(4'b0001, 4);
    push_run(4'b1000, 4);
    for (int j = 0; j < 4; j++) apply_stimulus(4'b1001, 4'b1001);
    raddr[0] = 18'h00010;
    apply_stimulus(4'b1001, 4'b1000);
    check_output("handover_final_grant", 32'(bus.grant), 32'h1);
    push_read(0, 18'h00010);
    apply_stimulus(4'b1001, 4'b1001);
    check_output("handover_idle", 32'(bus.grant), 32'd0);
    for (int j = 6; j < 9; j++) begin
      apply_stimulus(4'b1001, 4'b1001);
      if (j == 6) check_output("handover_grant3", 32'(bus.grant), 32'h8);
    end
    apply_stimulus('0, '0);
    apply_stimulus('0, '0);

    // Asynchronous reset in the middle of a grant, with an rvalid showing.
    do_reset();
    raddr[1] = 18'h00345;
    push_run(4'b0010, 3);
    push_run(4'b0001, 2);
    apply_stimulus(4'b0010, 4'b0010);
    apply_stimulus(4'b0010, 4'b0010);
    apply_stimulus(4'b0010, 4'b0000);
    push_read(1, raddr[1]);
    apply_stimulus(4'b0010, 4'b0010);
    check_output("pre_reset_wr_enable", 32'(bus.sram_wr_enable), 32'd1);
    check_output("pre_reset_rvalid", 32'(bus.req_rvalid), 32'h2);
    #2 reset = 1'b0;
    #1;
    check_output("async_reset_grant", 32'(bus.grant), 32'd0);
    check_output("async_reset_rvalid", 32'(bus.req_rvalid), 32'd0);
    check_output("async_reset_wr_enable", 32'(bus.sram_wr_enable), 32'd0);
    check_output("async_reset_busy", 32'(bus.busy), 32'd0);
    apply_stimulus('0, '0);
    apply_stimulus(4'b0011, 4'b0011);
    reset = 1'b1;
    apply_stimulus(4'b0011, 4'b0011);
    check_output("post_reset_grant", 32'(bus.grant), 32'h1);
    apply_stimulus('0, '0);
    apply_stimulus('0, '0);
    apply_stimulus('0, '0);
    apply_stimulus('0, '0);

    check_output("runs_drained", exp_runs.size(), 32'd0);
    check_output("reads_drained", exp_reads.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
